wb_arbiter: RTL and testbench

- Write-back arbiter feeding the single write port of the 32x64 register file (write / wrAddr / wrData).
- Merges two producers: the memory-load return path (unbuffered, priority) and the ALU result path (buffered in a DEPTH-entry FIFO).
- Anti-starvation counter guarantees ALU forward progress.
- Exports a pending-write scoreboard for upstream hazard stalls.

---
 rtl/wb_arbiter.sv | 115 +++++++++++
 tb/tb_wb_arbiter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - write-back arbiter: priority load path, FIFO-buffered ALU path, anti-starvation (option: WB_BYPASS_EN)
module wb_arbiter #(
    parameter int DATA_W     = 64,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_addr,
    input  logic [DATA_W-1:0]        alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_addr,
    input  logic [DATA_W-1:0]        mem_data,
    output logic                     write,
    output logic [4:0]               wrAddr,
    output logic [DATA_W-1:0]        wrData,
    output logic [31:0]              pending,
    output logic [$clog2(DEPTH):0]   alu_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]        r_fifo_addr [DEPTH];
    logic [DATA_W-1:0] r_fifo_data [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic [SW-1:0]     r_starve;

    logic        w_empty;
    logic        w_full;
    logic        w_force_alu;
    logic        w_mem_win;
    logic        w_pop;
    logic        w_push;
    logic        w_bypass;
    logic [AW:0] w_count;

    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                         (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_count     = r_wr_ptr - r_rd_ptr;
    assign w_force_alu = (r_starve == SW'(STARVE_MAX));

    assign alu_ready = ~w_full;
    assign mem_ready = ~w_force_alu;
    assign alu_count = w_count;

    // Register 31 is the zero register: accepted on both paths but never written.
    assign w_mem_win = mem_valid & mem_ready & (mem_addr != 5'd31);
    assign w_pop     = ~w_mem_win & ~w_empty;

`ifdef WB_BYPASS_EN
    assign w_bypass = w_empty & ~w_mem_win & alu_valid & (alu_addr != 5'd31);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = alu_valid & alu_ready & (alu_addr != 5'd31) & ~w_bypass;

    // A physical slot is valid when its distance from the read pointer is below the occupancy.
    always_comb begin
        pending = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if ({1'b0, AW'(AW'(j) - r_rd_ptr[AW-1:0])} < w_count)
                pending[r_fifo_addr[j]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr[AW-1:0]] <= alu_addr;
            r_fifo_data[r_wr_ptr[AW-1:0]] <= alu_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_starve <= '0;
            write    <= 1'b0;
            wrAddr   <= '0;
            wrData   <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;

            if (w_pop || w_empty)
                r_starve <= '0;
            else if (w_mem_win)
                r_starve <= r_starve + 1'b1;

            if (w_mem_win) begin
                write  <= 1'b1;
                wrAddr <= mem_addr;
                wrData <= mem_data;
            end else if (!w_empty) begin
                write  <= 1'b1;
                wrAddr <= r_fifo_addr[r_rd_ptr[AW-1:0]];
                wrData <= r_fifo_data[r_rd_ptr[AW-1:0]];
            end else if (w_bypass) begin
                write  <= 1'b1;
                wrAddr <= alu_addr;
                wrData <= alu_data;
            end else begin
                write  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - randomized and directed bench for wb_arbiter against a queue-based model
module tb_wb_arbiter;
    localparam int DATA_W     = 64;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              alu_valid, mem_valid;
    logic              alu_ready, mem_ready;
    logic [4:0]        alu_addr, mem_addr;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              write;
    logic [4:0]        wrAddr;
    logic [DATA_W-1:0] wrData;
    logic [31:0]       pending;
    logic [2:0]        alu_count;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [4:0]        a;
        logic [DATA_W-1:0] d;
    } ent_t;

    ent_t              q[$];
    int                m_starve;
    logic              m_write;
    logic [4:0]        m_addr;
    logic [DATA_W-1:0] m_data;

    always #5 clk = ~clk;

    wb_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .pending(pending), .alu_count(alu_count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] m_pending();
        logic [31:0] p = '0;
        foreach (q[i]) p[q[i].a] = 1'b1;
        return p;
    endfunction

    task automatic model_reset();
        q.delete();
        m_starve = 0;
        m_write  = 1'b0;
        m_addr   = '0;
        m_data   = '0;
    endtask

    task automatic check_outputs(input string ph);
        check({ph, ".write"},  64'(write),  64'(m_write));
        check({ph, ".wrAddr"}, 64'(wrAddr), 64'(m_addr));
        check({ph, ".wrData"}, wrData,      m_data);
    endtask

    task automatic cycle(input logic av, input logic [4:0] aa, input logic [63:0] ad,
                         input logic mv, input logic [4:0] ma, input logic [63:0] md);
        bit force_alu, mem_win, alu_acc, was_empty, popped, bypass;
        ent_t e;
        @(negedge clk);
        alu_valid = av; alu_addr = aa; alu_data = ad;
        mem_valid = mv; mem_addr = ma; mem_data = md;
        #1;
        force_alu = (m_starve == STARVE_MAX);
        check("alu_ready", 64'(alu_ready), 64'(q.size() < DEPTH));
        check("mem_ready", 64'(mem_ready), 64'(!force_alu));
        check("alu_count", 64'(alu_count), 64'(q.size()));
        check("pending",   64'(pending),   64'(m_pending()));

        mem_win   = mv && !force_alu && (ma != 5'd31);
        alu_acc   = av && (q.size() < DEPTH);
        was_empty = (q.size() == 0);
        popped    = 1'b0;
        bypass    = 1'b0;
        if (mem_win) begin
            m_write = 1'b1; m_addr = ma; m_data = md;
        end else if (!was_empty) begin
            e = q.pop_front();
            popped = 1'b1;
            m_write = 1'b1; m_addr = e.a; m_data = e.d;
        end else begin
`ifdef WB_BYPASS_EN
            bypass = av && (aa != 5'd31);
`endif
            if (bypass) begin
                m_write = 1'b1; m_addr = aa; m_data = ad;
            end else begin
                m_write = 1'b0;
            end
        end
        if (alu_acc && aa != 5'd31 && !bypass) begin
            e.a = aa; e.d = ad;
            q.push_back(e);
        end
        if (popped || was_empty) m_starve = 0;
        else if (mem_win)        m_starve++;

        @(posedge clk);
        #1;
        check_outputs("edge");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0);
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
    endfunction

    initial begin
        reset = 1'b0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        model_reset();
        #12;
        check("rst.write",     64'(write),     64'd0);
        check("rst.wrAddr",    64'(wrAddr),    64'd0);
        check("rst.wrData",    wrData,         64'd0);
        check("rst.alu_count", 64'(alu_count), 64'd0);
        check("rst.pending",   64'(pending),   64'd0);
        check("rst.mem_ready", 64'(mem_ready), 64'd1);
        check("rst.alu_ready", 64'(alu_ready), 64'd1);
        @(negedge clk);
        reset = 1'b1;

        // Single ALU push, then let it drain.
        cycle(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0);
        idle(3);

        // ALU pushes 1..5 while loads keep the port busy so the FIFO fills.
        for (int i = 1; i <= 5; i++)
            cycle(1'b1, 5'(i), 64'(i * 16), 1'b1, 5'd20, 64'h55);
        idle(6);

        // Starvation: one queued ALU entry against continuous loads.
        cycle(1'b1, 5'd7, 64'h77, 1'b1, 5'd9, 64'hAA);
        for (int i = 0; i < 8; i++) cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'hAA);
        idle(3);

        // Zero-register traffic on both paths.
        cycle(1'b1, 5'd31, 64'hDEAD, 1'b1, 5'd31, 64'hBEEF);
        idle(2);

        // Load to r31 while the FIFO holds r2.
        cycle(1'b1, 5'd2, 64'h22, 1'b1, 5'd12, 64'hC);
        cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd31, 64'hF);
        idle(2);

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 5'(10 + i), 64'(100 + i), 1'b1, 5'd3, 64'h3);
        @(negedge clk);
        alu_valid = 1'b0; mem_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        check("async_rst.alu_count", 64'(alu_count), 64'd0);
        check("async_rst.pending",   64'(pending),   64'd0);
        @(negedge clk);
        reset = 1'b1;
        idle(4);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 9) < 6), rnd_addr(), {$urandom, $urandom},
                  1'($urandom_range(0, 9) < 5), rnd_addr(), {$urandom, $urandom});
        idle(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
